// File: rtl/regfile_dump_pkg.sv
// Shared types for the register-file dump engine: FSM state encoding and handshake helper.
package regfile_dump_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    FLUSH   = 2'd2,
    DONE_ST = 2'd3
  } state_e;

  function automatic logic fire(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/regfile_dump_if.sv
// Register-file read port plus valid/ready output stream of the dump engine.
interface regfile_dump_if #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1
);
  logic [ADDR_WIDTH-1:0] rf_addr;
  logic [DATA_WIDTH-1:0] rf_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    output rf_addr,
    input  rf_data,
    output out_valid, out_addr, out_data, out_last,
    input  out_ready
  );

  modport slave (
    input  rf_addr,
    output rf_data,
    input  out_valid, out_addr, out_data, out_last,
    output out_ready
  );
endinterface

// File: rtl/regfile_dump_obuf.sv
// Single-entry output register {addr, data, last}; loads when empty or when the held word drains.
module regfile_dump_obuf
  import regfile_dump_pkg::*;
#(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  last_i,
  input  logic                  ready_i,
  output logic                  can_load_o,
  output logic                  valid_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o
);
  logic                  valid_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  last_q;

  assign can_load_o = !valid_q || ready_i;

  // Flush wins over a same-cycle load or handshake so an aborted word never survives.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i && can_load_o) begin
      valid_q <= 1'b1;
      addr_q  <= addr_i;
      data_q  <= data_i;
      last_q  <= last_i;
    end else if (fire(valid_q, ready_i)) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
endmodule

// File: rtl/regfile_dump.sv
// Sweeps register-file addresses LO..HI through one read port and streams (addr, data) pairs.
// Optional abort input enabled by defining REGFILE_DUMP_ABORT_EN.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1,
  parameter int LO         = 0,
  parameter int HI         = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
`ifdef REGFILE_DUMP_ABORT_EN
  input  logic abort_i,
`endif
  output logic busy_o,
  output logic done_o,
  regfile_dump_if.master bus
);
  localparam logic [ADDR_WIDTH-1:0] LO_A = ADDR_WIDTH'(LO);
  localparam logic [ADDR_WIDTH-1:0] HI_A = ADDR_WIDTH'(HI);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  abort;
  logic                  can_load;
  logic                  capture;
  logic                  ptr_at_hi;

`ifdef REGFILE_DUMP_ABORT_EN
  assign abort = abort_i && (state_q == RUN || state_q == FLUSH);
`else
  assign abort = 1'b0;
`endif

  assign capture   = (state_q == RUN) && can_load && !abort;
  // End of sweep is an equality compare so HI at the top of the address space cannot wrap.
  assign ptr_at_hi = (ptr_q == HI_A);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= LO_A;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q != RUN) ptr_d = LO_A;
    else if (capture)   ptr_d = ptr_q + ADDR_WIDTH'(1);
    unique case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (capture && ptr_at_hi) state_d = FLUSH;
      FLUSH:   if (fire(bus.out_valid, bus.out_ready)) state_d = DONE_ST;
      DONE_ST: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_comb begin
    busy_o = (state_q != IDLE);
    done_o = (state_q == DONE_ST);
  end

  assign bus.rf_addr = (state_q == RUN) ? ptr_q : LO_A;

  regfile_dump_obuf #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_obuf (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (abort),
    .load_i     (capture),
    .addr_i     (ptr_q),
    .data_i     (bus.rf_data),
    .last_i     (ptr_at_hi),
    .ready_i    (bus.out_ready),
    .can_load_o (can_load),
    .valid_o    (bus.out_valid),
    .addr_o     (bus.out_addr),
    .data_o     (bus.out_data),
    .last_o     (bus.out_last)
  );
endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench: three dump engines (0..7, 5..7, 3..3) over 8-entry files, checked against a queue model.
module tb_regfile_dump;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [2:0] start_s, ready_s, abort_s;
  logic [2:0] busy_w, done_w, valid_w, last_w;
  logic [2:0] oaddr_w [3];
  logic [7:0] odata_w [3];
  logic [2:0] rfaddr_w [3];
  logic [7:0] mem [3][8];

  regfile_dump_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) bus0 ();
  regfile_dump_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) bus1 ();
  regfile_dump_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) bus2 ();

  regfile_dump #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .LO(0), .HI(7)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start_s[0]),
`ifdef REGFILE_DUMP_ABORT_EN
    .abort_i(abort_s[0]),
`endif
    .busy_o(busy_w[0]), .done_o(done_w[0]), .bus(bus0));
  regfile_dump #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .LO(5), .HI(7)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start_s[1]),
`ifdef REGFILE_DUMP_ABORT_EN
    .abort_i(abort_s[1]),
`endif
    .busy_o(busy_w[1]), .done_o(done_w[1]), .bus(bus1));
  regfile_dump #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .LO(3), .HI(3)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start_s[2]),
`ifdef REGFILE_DUMP_ABORT_EN
    .abort_i(abort_s[2]),
`endif
    .busy_o(busy_w[2]), .done_o(done_w[2]), .bus(bus2));

  assign bus0.out_ready = ready_s[0];
  assign bus1.out_ready = ready_s[1];
  assign bus2.out_ready = ready_s[2];
  assign bus0.rf_data = mem[0][bus0.rf_addr];
  assign bus1.rf_data = mem[1][bus1.rf_addr];
  assign bus2.rf_data = mem[2][bus2.rf_addr];
  assign valid_w[0] = bus0.out_valid;  assign valid_w[1] = bus1.out_valid;  assign valid_w[2] = bus2.out_valid;
  assign last_w[0]  = bus0.out_last;   assign last_w[1]  = bus1.out_last;   assign last_w[2]  = bus2.out_last;
  assign oaddr_w[0] = bus0.out_addr;   assign oaddr_w[1] = bus1.out_addr;   assign oaddr_w[2] = bus2.out_addr;
  assign odata_w[0] = bus0.out_data;   assign odata_w[1] = bus1.out_data;   assign odata_w[2] = bus2.out_data;
  assign rfaddr_w[0] = bus0.rf_addr;   assign rfaddr_w[1] = bus1.rf_addr;   assign rfaddr_w[2] = bus2.rf_addr;

  // mode: 0 = READY always high, 1 = READY toggling 1,0,1,0, 2 = random READY
  task automatic sweep(input int id, input int lo, input int hi, input int mode,
                       input bit fixed, input bit poke_start);
    int         q_addr[$];
    logic [7:0] q_data[$];
    logic [2:0] pa;
    logic [7:0] pd;
    logic       pl, pv, pr;
    bit         seen_done;
    int         n;
    for (int a = 0; a < 8; a++) mem[id][a] = fixed ? 8'(8'h10 + a) : 8'($urandom);
    for (int a = lo; a <= hi; a++) begin
      q_addr.push_back(a);
      q_data.push_back(mem[id][a]);
    end
    @(negedge clk); start_s[id] = 1'b1;
    @(posedge clk);
    @(negedge clk); start_s[id] = 1'b0;
    checks++; if (busy_w[id] !== 1'b1) begin errors++; $error("FAIL busy_k1: observed=%0h expected=%0h", busy_w[id], 1'b1); end
    checks++; if (rfaddr_w[id] !== 3'(lo)) begin errors++; $error("FAIL rfaddr_k1: observed=%0h expected=%0h", rfaddr_w[id], 3'(lo)); end
    checks++; if (valid_w[id] !== 1'b0) begin errors++; $error("FAIL valid_k1: observed=%0h expected=%0h", valid_w[id], 1'b0); end
    pv = 1'b0; pr = 1'b0; pa = '0; pd = '0; pl = 1'b0;
    seen_done = 1'b0;
    for (n = 1; n < 80 && !seen_done; n++) begin
      if (n > 1) @(negedge clk);
      if (poke_start) start_s[id] = (n == 3);
      ready_s[id] = (mode == 0) ? 1'b1 : (mode == 1) ? ((n % 2) == 1) : 1'($urandom_range(0, 1));
      checks++; if (busy_w[id] !== 1'b1) begin errors++; $error("FAIL busy_run: observed=%0h expected=%0h", busy_w[id], 1'b1); end
      if (pv && !pr) begin
        checks++; if (valid_w[id] !== 1'b1) begin errors++; $error("FAIL hold_valid: observed=%0h expected=%0h", valid_w[id], 1'b1); end
        checks++; if (oaddr_w[id] !== pa) begin errors++; $error("FAIL hold_addr: observed=%0h expected=%0h", oaddr_w[id], pa); end
        checks++; if (odata_w[id] !== pd) begin errors++; $error("FAIL hold_data: observed=%0h expected=%0h", odata_w[id], pd); end
        checks++; if (last_w[id] !== pl) begin errors++; $error("FAIL hold_last: observed=%0h expected=%0h", last_w[id], pl); end
      end
      if (mode == 0 && n >= 2 && n <= 2 + hi - lo) begin
        checks++; if (valid_w[id] !== 1'b1) begin errors++; $error("FAIL stream_valid: observed=%0h expected=%0h", valid_w[id], 1'b1); end
        checks++; if (oaddr_w[id] !== 3'(lo + n - 2)) begin errors++; $error("FAIL stream_addr: observed=%0h expected=%0h", oaddr_w[id], 3'(lo + n - 2)); end
      end
      if (valid_w[id] && ready_s[id]) begin
        checks++; if ((q_addr.size() > 0) !== 1'b1) begin errors++; $error("FAIL extra_word: observed=%0h expected=%0h", q_addr.size(), 1); end
        if (q_addr.size() > 0) begin
          checks++; if (oaddr_w[id] !== 3'(q_addr[0])) begin errors++; $error("FAIL hs_addr: observed=%0h expected=%0h", oaddr_w[id], 3'(q_addr[0])); end
          checks++; if (odata_w[id] !== q_data[0]) begin errors++; $error("FAIL hs_data: observed=%0h expected=%0h", odata_w[id], q_data[0]); end
          checks++; if (last_w[id] !== (q_addr[0] == hi)) begin errors++; $error("FAIL hs_last: observed=%0h expected=%0h", last_w[id], (q_addr[0] == hi)); end
          void'(q_addr.pop_front());
          void'(q_data.pop_front());
        end
      end
      if (done_w[id]) begin
        seen_done = 1'b1;
        checks++; if (q_addr.size() !== 0) begin errors++; $error("FAIL words_left: observed=%0h expected=%0h", q_addr.size(), 0); end
        checks++; if (valid_w[id] !== 1'b0) begin errors++; $error("FAIL done_valid: observed=%0h expected=%0h", valid_w[id], 1'b0); end
        if (mode == 0) begin
          checks++; if (n !== 3 + hi - lo) begin errors++; $error("FAIL done_cycle: observed=%0h expected=%0h", n, 3 + hi - lo); end
        end
      end
      pv = valid_w[id]; pr = ready_s[id];
      pa = oaddr_w[id]; pd = odata_w[id]; pl = last_w[id];
    end
    checks++; if (seen_done !== 1'b1) begin errors++; $error("FAIL done_seen: observed=%0h expected=%0h", seen_done, 1'b1); end
    start_s[id] = 1'b0;
    ready_s[id] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++; if (busy_w[id] !== 1'b0) begin errors++; $error("FAIL idle_busy: observed=%0h expected=%0h", busy_w[id], 1'b0); end
      checks++; if (done_w[id] !== 1'b0) begin errors++; $error("FAIL idle_done: observed=%0h expected=%0h", done_w[id], 1'b0); end
      checks++; if (valid_w[id] !== 1'b0) begin errors++; $error("FAIL idle_valid: observed=%0h expected=%0h", valid_w[id], 1'b0); end
      checks++; if (rfaddr_w[id] !== 3'(lo)) begin errors++; $error("FAIL idle_rfaddr: observed=%0h expected=%0h", rfaddr_w[id], 3'(lo)); end
    end
  endtask

  initial begin
    bit found;
    rst = 1'b1; start_s = '0; ready_s = '0; abort_s = '0;
    for (int i = 0; i < 3; i++) for (int a = 0; a < 8; a++) mem[i][a] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy_w !== 3'b000) begin errors++; $error("FAIL rst_busy0: observed=%0h expected=%0h", busy_w, 3'b000); end
    checks++; if (done_w !== 3'b000) begin errors++; $error("FAIL rst_done0: observed=%0h expected=%0h", done_w, 3'b000); end
    checks++; if (valid_w !== 3'b000) begin errors++; $error("FAIL rst_valid0: observed=%0h expected=%0h", valid_w, 3'b000); end
    checks++; if (last_w !== 3'b000) begin errors++; $error("FAIL rst_last0: observed=%0h expected=%0h", last_w, 3'b000); end
    checks++; if (oaddr_w[0] !== 3'd0) begin errors++; $error("FAIL rst_oaddr0: observed=%0h expected=%0h", oaddr_w[0], 3'd0); end
    checks++; if (odata_w[0] !== 8'd0) begin errors++; $error("FAIL rst_odata0: observed=%0h expected=%0h", odata_w[0], 8'd0); end
    checks++; if (rfaddr_w[0] !== 3'd0) begin errors++; $error("FAIL rst_rfaddr0: observed=%0h expected=%0h", rfaddr_w[0], 3'd0); end
    checks++; if (rfaddr_w[1] !== 3'd5) begin errors++; $error("FAIL rst_rfaddr1: observed=%0h expected=%0h", rfaddr_w[1], 3'd5); end
    checks++; if (rfaddr_w[2] !== 3'd3) begin errors++; $error("FAIL rst_rfaddr2: observed=%0h expected=%0h", rfaddr_w[2], 3'd3); end
    rst = 1'b0;

    sweep(0, 0, 7, 0, 1'b1, 1'b0);
    sweep(0, 0, 7, 1, 1'b1, 1'b1);
    sweep(0, 0, 7, 2, 1'b0, 1'b0);
    sweep(1, 5, 7, 0, 1'b0, 1'b0);
    sweep(1, 5, 7, 2, 1'b0, 1'b1);
    sweep(2, 3, 3, 0, 1'b0, 1'b0);
    sweep(2, 3, 3, 1, 1'b0, 1'b1);

    // reset while word 4 is pending
    @(negedge clk); start_s[0] = 1'b1;
    @(posedge clk);
    @(negedge clk); start_s[0] = 1'b0; ready_s[0] = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (valid_w[0] && oaddr_w[0] == 3'd4) begin
        found = 1'b1; ready_s[0] = 1'b0; rst = 1'b1;
      end else @(negedge clk);
    end
    checks++; if (found !== 1'b1) begin errors++; $error("FAIL rst_word4_seen: observed=%0h expected=%0h", found, 1'b1); end
    @(negedge clk);
    rst = 1'b0;
    checks++; if (valid_w[0] !== 1'b0) begin errors++; $error("FAIL midrst_valid: observed=%0h expected=%0h", valid_w[0], 1'b0); end
    checks++; if (busy_w[0] !== 1'b0) begin errors++; $error("FAIL midrst_busy: observed=%0h expected=%0h", busy_w[0], 1'b0); end
    checks++; if (done_w[0] !== 1'b0) begin errors++; $error("FAIL midrst_done: observed=%0h expected=%0h", done_w[0], 1'b0); end
    @(negedge clk);
    checks++; if (done_w[0] !== 1'b0) begin errors++; $error("FAIL midrst_nodone: observed=%0h expected=%0h", done_w[0], 1'b0); end
    sweep(0, 0, 7, 0, 1'b0, 1'b0);

`ifdef REGFILE_DUMP_ABORT_EN
    @(negedge clk); start_s[0] = 1'b1;
    @(posedge clk);
    @(negedge clk); start_s[0] = 1'b0; ready_s[0] = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (valid_w[0] && oaddr_w[0] == 3'd3) begin
        found = 1'b1; abort_s[0] = 1'b1;
      end else @(negedge clk);
    end
    checks++; if (found !== 1'b1) begin errors++; $error("FAIL abort_word3_seen: observed=%0h expected=%0h", found, 1'b1); end
    @(negedge clk);
    abort_s[0] = 1'b0;
    checks++; if (valid_w[0] !== 1'b0) begin errors++; $error("FAIL abort_valid: observed=%0h expected=%0h", valid_w[0], 1'b0); end
    checks++; if (busy_w[0] !== 1'b0) begin errors++; $error("FAIL abort_busy: observed=%0h expected=%0h", busy_w[0], 1'b0); end
    repeat (3) begin
      @(negedge clk);
      checks++; if (done_w[0] !== 1'b0) begin errors++; $error("FAIL abort_nodone: observed=%0h expected=%0h", done_w[0], 1'b0); end
      checks++; if (valid_w[0] !== 1'b0) begin errors++; $error("FAIL abort_novalid: observed=%0h expected=%0h", valid_w[0], 1'b0); end
    end
    sweep(0, 0, 7, 2, 1'b0, 1'b0);
`else
    $display("ABORT port not built; sweeps always run to DONE");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/regfile_dump.md
# regfile_dump

Sequential read-out engine for a multi-ported register file. On a START pulse it sweeps every address from `lo` to `hi` through one register-file read port. It streams each (address, data) pair out on a valid/ready interface, marking the final word with OUT_LAST. It sits between a register file's read port and a debug/trace or checkpoint sink, and is the drain counterpart to file-based initialization.

## Interface
- addr_width, 1, width of register-file address
- data_width, 1, width of register-file word
- lo, 0, first address swept (inclusive)
- hi, 1, last address swept (inclusive); must satisfy lo <= hi <= 2^addr_width-1
- CLK  in  1  clock; all state updates on posedge
- RST  in  1  reset; synchronous and active-high
- START  in  1  begin sweep; sampled only in IDLE
- BUSY  out  1  high from the cycle after START is accepted until DONE
- DONE  out  1  one-cycle pulse after the last word's handshake
- RF_ADDR  out  addr_width  drives the register-file read-port address
- RF_DATA  in  data_width  combinational read data for RF_ADDR, same cycle
- OUT_VALID  out  1  output word present
- OUT_READY  in  1  sink accepts the word when VALID&READY at posedge
- OUT_ADDR  out  addr_width  address of the presented word
- OUT_DATA  out  data_width  data of the presented word
- OUT_LAST  out  1  presented word is address `hi`

## Operation
- States:
  - IDLE -> RUN on START.
  - RUN -> FLUSH when word `hi` has been captured into the output register.
  - FLUSH -> DONE_ST when that word is handshaken.
  - DONE_ST -> IDLE unconditionally; DONE=1 only in DONE_ST.
- RUN:
  - Pointer `ptr` drives RF_ADDR.
  - Capture occurs when the output register is empty or its word is being accepted (!OUT_VALID | OUT_READY).
  - On capture: {OUT_ADDR, OUT_DATA} <= {ptr, RF_DATA}; OUT_VALID <= 1; OUT_LAST <= (ptr==hi); ptr increments.
- The last address is detected by comparison with `hi`, not by counter overflow. hi = 2^addr_width-1 must not wrap the pointer into a false extra word.
- Output stability: while OUT_VALID=1 and OUT_READY=0, OUT_ADDR, OUT_DATA and OUT_LAST are held constant.
- START in any state other than IDLE is ignored.
- Concurrent register-file writes are not blocked. Each word reflects the file contents in the cycle it was captured, so the sweep is not an atomic snapshot.
- Outside RUN, RF_ADDR holds `lo`.

## Timing
- Reset values:
  - state = IDLE
  - BUSY = 0, DONE = 0
  - OUT_VALID = 0, OUT_LAST = 0
  - OUT_ADDR = 0, OUT_DATA = 0
  - RF_ADDR = lo
- RST mid-sweep: return to IDLE on the next edge, with no DONE pulse and OUT_VALID dropped regardless of READY.
- Sequence with START high at edge k:
  - BUSY=1 from cycle k+1; RF_ADDR=lo in cycle k+1.
  - First OUT_VALID in cycle k+2.
- Throughput: with OUT_READY held high, one word per cycle. Word `hi` is presented in cycle k+2+(hi-lo); DONE pulses in cycle k+3+(hi-lo); BUSY falls in the same cycle DONE falls.
- Backpressure: the sweep stalls with zero word loss and no duplicates.
- lo==hi: single word with OUT_LAST=1; state passes RUN -> FLUSH immediately.

## Configuration
- REGFILE_DUMP_ABORT_EN:
  - Defined: adds input port ABORT (1 bit). ABORT=1 in RUN or FLUSH returns the block to IDLE on the next edge. OUT_VALID is cleared, the pending word is discarded, and no DONE pulse is issued. ABORT takes priority over a simultaneous handshake.
  - Undefined: no ABORT port; a sweep always runs to DONE.

## Structure
- Package regfile_dump_pkg:
  - State encoding: IDLE=2'd0, RUN=2'd1, FLUSH=2'd2, DONE_ST=2'd3.
  - Handshake helper function fire(valid, ready).
- One sub-module, regfile_dump_obuf: single-entry output register holding {addr, data, last} with valid/ready, load-when-empty-or-draining. The top level holds the FSM and pointer.

## Test plan
- Sweep with lo=0, hi=7, data_width=8, arr[i]=0x10+i, READY=1: words (0,0x10)..(7,0x17) on 8 consecutive cycles starting at k+2; LAST only on addr 7; DONE at k+10.
- Same setup with READY toggling 1,0,1,0: each word held stable while READY=0; exactly 8 handshakes, in order, no duplicates.
- Edge range: addr_width=3, lo=5, hi=7 → addresses 5,6,7 only, no wrap to 0; lo=hi=3 → one word with LAST=1, then DONE.
- START pulsed during BUSY → ignored; sweep count stays 8.
- RST asserted while word 4 is pending → next cycle OUT_VALID=0, BUSY=0, no DONE; a fresh START restarts from addr 0.
- With REGFILE_DUMP_ABORT_EN: ABORT asserted at word 3 with READY=1 → VALID clears next cycle, no DONE; without the macro the bench confirms the ABORT port is absent.
